// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for an N x N systolic array: captures A and B on start and
// streams row i of A delayed by i cycles on the left edge, column j of B delayed by j on top.

module systolic_skew_lane #(
  parameter int W    = 4,
  parameter int N    = 4,
  parameter int LANE = 0,
  parameter int TW   = 3
)(
  input  logic [N-1:0][W-1:0] vec,
  input  logic [TW-1:0]       step,
  output logic [W-1:0]        sel
);
  // Lane LANE shows element (step - LANE) of its vector, zero outside the matrix.
  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++)
      if (int'(step) == LANE + k) sel = vec[k];
  end
endmodule

module systolic_skew_feeder #(
  parameter int DATA_WIDTH   = 4,
  parameter int N            = 4,
  parameter int DRAIN_CYCLES = N
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N*N*DATA_WIDTH-1:0]    a_flat,
  input  logic [N*N*DATA_WIDTH-1:0]    b_flat,
  output logic [N*DATA_WIDTH-1:0]      left_out,
  output logic [N*DATA_WIDTH-1:0]      top_out,
  output logic                         feed_valid,
  output logic                         busy,
  output logic                         done
);
  localparam int FLAST = 2*N - 2;
  localparam int DLAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int TMAX  = (FLAST > DRAIN_CYCLES) ? FLAST : DRAIN_CYCLES;
  localparam int TW    = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;
  typedef logic [N-1:0][DATA_WIDTH-1:0]        lane_t;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] t, t_n;
  mat_t          a_cap, b_cap, a_src, b_src;
  lane_t         left_sel, top_sel, left_n, top_n, left_r, top_r;
  logic          feed_n, busy_n, done_n;

  // Step 0 is registered on the start edge itself, so it must read the live inputs.
  assign a_src = (state == IDLE) ? mat_t'(a_flat) : a_cap;
  assign b_src = (state == IDLE) ? mat_t'(b_flat) : b_cap;

  for (genvar i = 0; i < N; i++) begin : g_lane
    lane_t col;
    for (genvar k = 0; k < N; k++) begin : g_col
      assign col[k] = b_src[k][i];
    end
    systolic_skew_lane #(.W(DATA_WIDTH), .N(N), .LANE(i), .TW(TW)) u_left (
      .vec(a_src[i]), .step(t_n), .sel(left_sel[i]));
    systolic_skew_lane #(.W(DATA_WIDTH), .N(N), .LANE(i), .TW(TW)) u_top (
      .vec(col), .step(t_n), .sel(top_sel[i]));
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE:  if (start) begin state_n = FEED; t_n = '0; end
      FEED:  if (t == TW'(FLAST)) begin
               state_n = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
               t_n     = '0;
             end else t_n = t + 1'b1;
      DRAIN: if (t == TW'(DLAST)) begin state_n = DONE; t_n = '0; end
             else t_n = t + 1'b1;
      DONE:  begin state_n = IDLE; t_n = '0; end
      default: begin state_n = IDLE; t_n = '0; end
    endcase
  end

  always_comb begin
    feed_n = (state_n == FEED);
    busy_n = (state_n == FEED) || (state_n == DRAIN);
    done_n = (state_n == DONE);
    left_n = feed_n ? left_sel : '0;
    top_n  = feed_n ? top_sel  : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      t          <= '0;
      a_cap      <= '0;
      b_cap      <= '0;
      left_r     <= '0;
      top_r      <= '0;
      feed_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      t     <= t_n;
      if (state == IDLE && start) begin
        a_cap <= mat_t'(a_flat);
        b_cap <= mat_t'(b_flat);
      end
      left_r     <= left_n;
      top_r      <= top_n;
      feed_valid <= feed_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  assign left_out = left_r;
  assign top_out  = top_r;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder against a per-cycle expectation schedule,
// plus directed literal checks on a 2x2 and a 4x4 instance.

module tb_systolic_skew_feeder;
  localparam int N = 2, W = 4, D = 2;
  localparam int RUN = 2*N + D;          // cycles from start edge to the done cycle
  localparam int PERIOD = 2*N - 1 + D + 2;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, start4 = 1'b0;
  logic [N*N*W-1:0] a_flat = '0, b_flat = '0;
  logic [N*W-1:0]   left_out, top_out;
  logic             feed_valid, busy, done;
  logic [63:0]      a4 = '0, b4 = '0;
  logic [15:0]      left4, top4;
  logic             fv4, busy4, done4;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, busy_until = -1;
  bit chk_en = 1'b0;
  bit [N*W-1:0] exp_l [0:4095];
  bit [N*W-1:0] exp_t [0:4095];
  bit exp_f [0:4095];
  bit exp_b [0:4095];
  bit exp_d [0:4095];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(W), .N(N), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .left_out(left_out), .top_out(top_out), .feed_valid(feed_valid),
    .busy(busy), .done(done));

  systolic_skew_feeder #(.DATA_WIDTH(4), .N(4), .DRAIN_CYCLES(0)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_flat(a4), .b_flat(b4),
    .left_out(left4), .top_out(top4), .feed_valid(fv4),
    .busy(busy4), .done(done4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [N*W-1:0] skew_left(input bit [N*N*W-1:0] m, input int s);
    skew_left = '0;
    for (int i = 0; i < N; i++)
      if (s - i >= 0 && s - i < N) skew_left[i*W +: W] = m[(i*N + s - i)*W +: W];
  endfunction

  function automatic bit [N*W-1:0] skew_top(input bit [N*N*W-1:0] m, input int s);
    skew_top = '0;
    for (int j = 0; j < N; j++)
      if (s - j >= 0 && s - j < N) skew_top[j*W +: W] = m[((s - j)*N + j)*W +: W];
  endfunction

  // Reference: each accepted start books the whole run into per-cycle expectation tables.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= RUN; k++) begin
        exp_l[cyc+k] <= '0; exp_t[cyc+k] <= '0;
        exp_f[cyc+k] <= 0;  exp_b[cyc+k] <= 0; exp_d[cyc+k] <= 0;
      end
      busy_until <= cyc;
    end else if (start && cyc > busy_until) begin
      for (int s = 0; s < 2*N - 1; s++) begin
        exp_l[cyc+1+s] <= skew_left(a_flat, s);
        exp_t[cyc+1+s] <= skew_top(b_flat, s);
        exp_f[cyc+1+s] <= 1;
        exp_b[cyc+1+s] <= 1;
      end
      for (int d = 0; d < D; d++) exp_b[cyc+2*N+d] <= 1;
      exp_d[cyc+RUN] <= 1;
      busy_until     <= cyc + RUN;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("left_out",   64'(left_out),   64'(exp_l[cyc]));
      check("top_out",    64'(top_out),    64'(exp_t[cyc]));
      check("feed_valid", 64'(feed_valid), 64'(exp_f[cyc]));
      check("busy",       64'(busy),       64'(exp_b[cyc]));
      check("done",       64'(done),       64'(exp_d[cyc]));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_basic(input string tag);
    a_flat = 16'h4321; b_flat = 16'h8765; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " s0 left"}, 64'(left_out), 64'h01);
    check({tag, " s0 top"},  64'(top_out),  64'h05);
    check({tag, " s0 model"}, 64'(exp_l[cyc]), 64'h01);
    @(negedge clk);
    check({tag, " s1 left"}, 64'(left_out), 64'h32);
    check({tag, " s1 top"},  64'(top_out),  64'h67);
    @(negedge clk);
    check({tag, " s2 left"}, 64'(left_out), 64'h40);
    check({tag, " s2 top"},  64'(top_out),  64'h80);
    check({tag, " s2 fv"},   64'(feed_valid), 64'h1);
    @(negedge clk);
    check({tag, " drain fv"},   64'(feed_valid), 64'h0);
    check({tag, " drain busy"}, 64'(busy), 64'h1);
    @(negedge clk);
    check({tag, " drain2 busy"}, 64'(busy), 64'h1);
    @(negedge clk);
    check({tag, " done"},      64'(done), 64'h1);
    check({tag, " done busy"}, 64'(busy), 64'h0);
    @(negedge clk);
    check({tag, " after done"}, 64'(done), 64'h0);
  endtask

  initial begin
    int dq[$];
    int dn, fvc, done_k;
    logic [15:0] l4s3, t4s3;

    idle(3);
    reset = 1'b1;
    chk_en = 1'b1;
    check("reset left", 64'(left_out), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done4", 64'(done4), 64'h0);

    run_basic("basic");
    idle(2);

    // Signed operands pass through bit-exact.
    a_flat = 16'hD7F8; b_flat = 16'hEEEE; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("signed s1 left", 64'(left_out), 64'h7F);
    check("signed s1 top",  64'(top_out),  64'hEE);
    idle(6);

    // Restart and operand changes while busy are ignored.
    a_flat = 16'h4321; b_flat = 16'h8765; start = 1'b1;
    @(negedge clk);
    a_flat = 16'h9ABC; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy-restart s1 left", 64'(left_out), 64'h32);
    @(negedge clk);
    check("busy-restart s2 left", 64'(left_out), 64'h40);
    dn = 0;
    repeat (8) begin @(negedge clk); if (done) dn++; end
    check("busy-restart done count", 64'(dn), 64'd1);

    // Reset mid-run aborts without a done pulse.
    a_flat = 16'h4321; b_flat = 16'h8765; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    check("abort left", 64'(left_out), 64'h0);
    check("abort busy", 64'(busy), 64'h0);
    dn = 0;
    repeat (8) begin @(negedge clk); if (done) dn++; end
    check("abort done count", 64'(dn), 64'd0);
    run_basic("post-abort");
    idle(2);

    // Start held high: runs repeat every PERIOD cycles.
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (done) dq.push_back(k);
    end
    start = 1'b0;
    check("b2b done count", 64'(dq.size()), 64'd2);
    if (dq.size() == 2) begin
      check("b2b first done",  64'(dq[0]), 64'd6);
      check("b2b second done", 64'(dq[1]), 64'(6 + PERIOD));
    end
    idle(10);

    // Randomized traffic including occasional resets.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      reset  = ($urandom_range(0, 39) != 0);
      a_flat = 16'($urandom);
      b_flat = 16'($urandom);
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    idle(10);

    // 4x4, no drain phase.
    a4 = 64'hFEDCBA9876543210; b4 = 64'hFEDCBA9876543210; start4 = 1'b1;
    fvc = 0; done_k = 0; l4s3 = '0; t4s3 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (fv4) fvc++;
      if (k == 4) begin l4s3 = left4; t4s3 = top4; end
      if (done4 && done_k == 0) done_k = k;
    end
    check("n4 feed cycles", 64'(fvc), 64'd7);
    check("n4 s3 left", 64'(l4s3), 64'hC963);
    check("n4 s3 top",  64'(t4s3), 64'h369C);
    check("n4 done cycle", 64'(done_k), 64'd8);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
